mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the ARMv4-subset core. It sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback steps, one state per clock. It decodes the same instruction subset as the single-cycle core: ADD/SUB/AND/ORR/MOV with immediate or register operand, LDR/STR with imm12, and B. It sits between the instruction register and the multicycle datapath, and holds the NZCV flag register and condition evaluation.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; returns FSM to FETCH, clears flags
- Instr  in  20  instruction register bits [31:12]: cond, op, funct, Rd
- ALUFlags  in  4  {N,Z,C,V} from ALU this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register WriteData, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  00=imm8, 01=imm12, 10=branch imm24<<2
- RegSrc  out  2  same meaning as single-cycle core
- RegWrite  out  1  register file write enable
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- MovFlag  out  1  route SrcB instead of ALU result (MOV)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8). Latch cond_q <= CondEx(Instr[31:28], Flags).
- DECODE next state by op:
  - op 01 -> MEMADR
  - op 00 with funct[5]=1 -> EXECI
  - op 00 with funct[5]=0 -> EXECR
  - op 10 -> BRANCH
  - op 11 -> FETCH, with no writes.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl=00. Next state is MEMRD if funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=cond_q, then FETCH.
- MEMWR: AdrSrc=1, MemWrite=cond_q, RegSrc=10, then FETCH.
- EXECR / EXECI: ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 with ImmSrc=00 (EXECI). Then ALUWB.
  - ALUControl from funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - funct[4:1]=1101 is MOV: MovFlag=cond_q, ALUControl=00.
  - Any other funct[4:1]: no register write in ALUWB.
- Flags, in EXECR/EXECI only:
  - N,Z <= ALUFlags[3:2] when S & cond_q.
  - C,V <= ALUFlags[1:0] when S & cond_q & (ADD|SUB).
- ALUWB: ResultSrc=00, RegWrite=cond_q, then FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ALUControl=00, ResultSrc=10, PCWrite=cond_q, RegSrc=01. Then FETCH.
- Rd=15 writeback: in MEMWB or ALUWB with Rd=1111, PCWrite=cond_q in addition to RegWrite.
- Condition codes: the standard 15 ARM codes. Cond 1111 evaluates false.
- All outputs are a combinational function of state, Instr and cond_q. Any output not listed for a state is 0.

## Timing
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, op 11 2.
- Instr is stable from DECODE onward, because IR is loaded at the end of FETCH.
- cond_q is sampled once per instruction, at the DECODE->next edge. A flag update in EXECx does not affect the same instruction's writeback.
- Reset values: state=FETCH, Flags=0000, cond_q=0. Outputs during reset equal the FETCH values: IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, all others 0. The datapath PC is itself held in reset.
- Reset asserted mid-instruction aborts immediately: no further writes, FETCH on the first edge after release.

## Structure
- Package mc_pkg:
  - state_t enum
  - ResultSrc, ALUSrcB, ImmSrc and ALUControl encoding localparams
  - cond code constants
- Sub-module mc_fsm: state register, next-state logic and per-state output decode.
- Top level: flag registers, cond_q, ALU decode, condition check (reuse condcheck) and PCWrite/RegWrite gating.

## Test plan
- Reset, then 3 idle fetches → 2-cycle FETCH→DECODE loop repeats with IRWrite high only in FETCH.
- ADDS R1,R0,#0 with R0=0 (E2901000): states FETCH, DECODE, EXECI, ALUWB. RegWrite in cycle 4. Flags become Z=1, C=0, V=0.
- SUBNE (cond 0001) after Z=1 → all 4 states visited; RegWrite=0 and Flags unchanged.
- LDR R2,[R0,#8] (E5902008): 5 cycles, AdrSrc=1 in MEMRD, ResultSrc=01 and RegWrite=1 in MEMWB. STR variant: 4 cycles, MemWrite=1 only in MEMWR.
- BEQ with Z=1 → 3 cycles, PCWrite=1 in BRANCH with ImmSrc=10; with Z=0 → PCWrite=0.
- Reset asserted during MEMWR → MemWrite drops immediately, and the FSM reaches DECODE in the second cycle after release.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : mc_pkg
// Description : Shared types and encodings for the multicycle control unit:
//               FSM state enum, datapath select encodings, condition codes
//               and the condition evaluation helper.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9
    } state_t;

    // ResultSrc encodings
    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_DATA      = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] c_SRCB_REG      = 2'b00;
    localparam logic [1:0] c_SRCB_IMM      = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR     = 2'b10;

    // ImmSrc encodings
    localparam logic [1:0] c_IMM_8         = 2'b00;
    localparam logic [1:0] c_IMM_12        = 2'b01;
    localparam logic [1:0] c_IMM_BR24      = 2'b10;

    // ALUControl encodings
    localparam logic [1:0] c_ALU_ADD       = 2'b00;
    localparam logic [1:0] c_ALU_SUB       = 2'b01;
    localparam logic [1:0] c_ALU_AND       = 2'b10;
    localparam logic [1:0] c_ALU_ORR       = 2'b11;

    // RegSrc encodings
    localparam logic [1:0] c_REGSRC_NONE   = 2'b00;
    localparam logic [1:0] c_REGSRC_BR     = 2'b01;
    localparam logic [1:0] c_REGSRC_STR    = 2'b10;

    // Data-processing command field (funct[4:1])
    localparam logic [3:0] c_CMD_AND       = 4'b0000;
    localparam logic [3:0] c_CMD_SUB       = 4'b0010;
    localparam logic [3:0] c_CMD_ADD       = 4'b0100;
    localparam logic [3:0] c_CMD_ORR       = 4'b1100;
    localparam logic [3:0] c_CMD_MOV       = 4'b1101;

    // ARM condition codes
    localparam logic [3:0] c_COND_EQ       = 4'b0000;
    localparam logic [3:0] c_COND_NE       = 4'b0001;
    localparam logic [3:0] c_COND_CS       = 4'b0010;
    localparam logic [3:0] c_COND_CC       = 4'b0011;
    localparam logic [3:0] c_COND_MI       = 4'b0100;
    localparam logic [3:0] c_COND_PL       = 4'b0101;
    localparam logic [3:0] c_COND_VS       = 4'b0110;
    localparam logic [3:0] c_COND_VC       = 4'b0111;
    localparam logic [3:0] c_COND_HI       = 4'b1000;
    localparam logic [3:0] c_COND_LS       = 4'b1001;
    localparam logic [3:0] c_COND_GE       = 4'b1010;
    localparam logic [3:0] c_COND_LT       = 4'b1011;
    localparam logic [3:0] c_COND_GT       = 4'b1100;
    localparam logic [3:0] c_COND_LE       = 4'b1101;
    localparam logic [3:0] c_COND_AL       = 4'b1110;

    // Evaluate a condition code against {N,Z,C,V}; the reserved code 1111 is false.
    function automatic logic condex(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic ok;
        {n, z, c, v} = nzcv;
        case (cond)
            c_COND_EQ: ok = z;
            c_COND_NE: ok = ~z;
            c_COND_CS: ok = c;
            c_COND_CC: ok = ~c;
            c_COND_MI: ok = n;
            c_COND_PL: ok = ~n;
            c_COND_VS: ok = v;
            c_COND_VC: ok = ~v;
            c_COND_HI: ok = c & ~z;
            c_COND_LS: ok = ~(c & ~z);
            c_COND_GE: ok = (n == v);
            c_COND_LT: ok = (n != v);
            c_COND_GT: ok = ~z & (n == v);
            c_COND_LE: ok = z | (n != v);
            c_COND_AL: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_fsm.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : mc_fsm
// Description : Main sequencer of the multicycle controller. Holds the state
//               register, computes the next state and decodes the
//               unconditional per-state datapath selects.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module mc_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_op,
    input  logic       i_funct_i,
    input  logic       i_funct_l,
    output state_t     o_state,
    output logic       o_fetch_pcwrite,
    output logic       o_irwrite,
    output logic       o_adrsrc,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_immsrc,
    output logic [1:0] o_resultsrc,
    output logic [1:0] o_regsrc
);

    state_t r_state;
    state_t w_next;

    // State register; reset aborts whatever is in flight and parks in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and per-state datapath selects.
    always_comb begin
        w_next          = ST_FETCH;
        o_fetch_pcwrite = 1'b0;
        o_irwrite       = 1'b0;
        o_adrsrc        = 1'b0;
        o_alusrca       = 1'b0;
        o_alusrcb       = c_SRCB_REG;
        o_immsrc        = c_IMM_8;
        o_resultsrc     = c_RES_ALUOUT;
        o_regsrc        = c_REGSRC_NONE;
        case (r_state)
            ST_FETCH: begin
                o_irwrite       = 1'b1;
                o_fetch_pcwrite = 1'b1;
                o_alusrca       = 1'b1;
                o_alusrcb       = c_SRCB_FOUR;
                o_resultsrc     = c_RES_ALURESULT;
                w_next          = ST_DECODE;
            end
            ST_DECODE: begin
                // PC+4 again, so a read of R15 sees PC+8
                o_alusrca   = 1'b1;
                o_alusrcb   = c_SRCB_FOUR;
                o_resultsrc = c_RES_ALURESULT;
                case (i_op)
                    2'b01:   w_next = ST_MEMADR;
                    2'b00:   w_next = i_funct_i ? ST_EXECI : ST_EXECR;
                    2'b10:   w_next = ST_BRANCH;
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                o_alusrcb = c_SRCB_IMM;
                o_immsrc  = c_IMM_12;
                w_next    = i_funct_l ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                o_adrsrc = 1'b1;
                w_next   = ST_MEMWB;
            end
            ST_MEMWB: begin
                o_resultsrc = c_RES_DATA;
                w_next      = ST_FETCH;
            end
            ST_MEMWR: begin
                o_adrsrc = 1'b1;
                o_regsrc = c_REGSRC_STR;
                w_next   = ST_FETCH;
            end
            ST_EXECR: begin
                o_alusrcb = c_SRCB_REG;
                w_next    = ST_ALUWB;
            end
            ST_EXECI: begin
                o_alusrcb = c_SRCB_IMM;
                o_immsrc  = c_IMM_8;
                w_next    = ST_ALUWB;
            end
            ST_ALUWB: begin
                o_resultsrc = c_RES_ALUOUT;
                w_next      = ST_FETCH;
            end
            ST_BRANCH: begin
                o_alusrcb   = c_SRCB_IMM;
                o_immsrc    = c_IMM_BR24;
                o_resultsrc = c_RES_ALURESULT;
                o_regsrc    = c_REGSRC_BR;
                w_next      = ST_FETCH;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : mc_controller
// Description : Multicycle control unit top. Owns the NZCV flag register and
//               the per-instruction condition latch, decodes the ALU
//               operation and gates every architectural write with the
//               condition result.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ALUControl,
    output logic        MovFlag
);

    // Instruction fields (Instr holds IR[31:12])
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic [3:0] w_cmd;
    logic       w_s;
    logic       w_unused;

    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_funct  = Instr[13:8];
    assign w_rd     = Instr[3:0];
    assign w_cmd    = w_funct[4:1];
    assign w_s      = w_funct[0];
    // Rn is consumed by the datapath only
    assign w_unused = &{1'b0, Instr[7:4]};

    state_t     w_state;
    logic       w_fetch_pcwrite;

    logic [3:0] r_flags;
    logic       r_cond_q;

    logic [1:0] w_alu_ctl;
    logic       w_is_mov;
    logic       w_is_addsub;
    logic       w_dp_valid;
    logic       w_exec;
    logic       w_regwrite;

    mc_fsm u_fsm (
        .clk             (clk),
        .reset           (reset),
        .i_op            (w_op),
        .i_funct_i       (w_funct[5]),
        .i_funct_l       (w_funct[0]),
        .o_state         (w_state),
        .o_fetch_pcwrite (w_fetch_pcwrite),
        .o_irwrite       (IRWrite),
        .o_adrsrc        (AdrSrc),
        .o_alusrca       (ALUSrcA),
        .o_alusrcb       (ALUSrcB),
        .o_immsrc        (ImmSrc),
        .o_resultsrc     (ResultSrc),
        .o_regsrc        (RegSrc)
    );

    // Data-processing decode: ALU op, MOV detection, and which ops write back.
    always_comb begin
        w_alu_ctl   = c_ALU_ADD;
        w_is_mov    = 1'b0;
        w_is_addsub = 1'b0;
        w_dp_valid  = 1'b1;
        case (w_cmd)
            c_CMD_ADD: begin
                w_alu_ctl   = c_ALU_ADD;
                w_is_addsub = 1'b1;
            end
            c_CMD_SUB: begin
                w_alu_ctl   = c_ALU_SUB;
                w_is_addsub = 1'b1;
            end
            c_CMD_AND: w_alu_ctl = c_ALU_AND;
            c_CMD_ORR: w_alu_ctl = c_ALU_ORR;
            c_CMD_MOV: begin
                w_alu_ctl = c_ALU_ADD;
                w_is_mov  = 1'b1;
            end
            default:   w_dp_valid = 1'b0;
        endcase
    end

    assign w_exec = (w_state == ST_EXECR) || (w_state == ST_EXECI);

    // Condition latch: evaluated once per instruction on leaving DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cond_q <= 1'b0;
        end else if (w_state == ST_DECODE) begin
            r_cond_q <= condex(w_cond, r_flags);
        end
    end

    // Flag register: N/Z on any S-suffixed passing op, C/V only for ADD/SUB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_exec && w_s && r_cond_q) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_is_addsub) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Architectural writes are all qualified by the latched condition.
    assign w_regwrite = r_cond_q &
                        ((w_state == ST_MEMWB) || ((w_state == ST_ALUWB) && w_dp_valid));

    assign RegWrite   = w_regwrite;
    assign PCWrite    = w_fetch_pcwrite
                      | ((w_state == ST_BRANCH) & r_cond_q)
                      | (w_regwrite & (w_rd == 4'hF));
    assign MemWrite   = (w_state == ST_MEMWR) & r_cond_q;
    assign ALUControl = w_exec ? w_alu_ctl : c_ALU_ADD;
    assign MovFlag    = w_exec & w_is_mov & r_cond_q;

endmodule
`default_nettype wire
